// File: rtl/adc_capture.sv
// adc_capture: dual-channel LTC1407A-style ADC read-out (AD_CONV strobe, 34-bit SPI frame, two 14-bit samples)
// Ports: clk, reset (sync, active-low), GO_ADC (start, IDLE only), SPI_MISO (ADC data)
//        AD_CONV, SPI_CLK_ADC, BUSY, DONE_ADC (1-cycle), ADC_CH0/ADC_CH1 (held until next DONE)
module adc_capture #(
    parameter int CLK_DIV   = 2,
    parameter int DATA_W    = 14,
    parameter int FRAME_LEN = 34
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              GO_ADC,
    input  logic              SPI_MISO,
    output logic              AD_CONV,
    output logic              SPI_CLK_ADC,
    output logic              BUSY,
    output logic              DONE_ADC,
    output logic [DATA_W-1:0] ADC_CH0,
    output logic [DATA_W-1:0] ADC_CH1
);
    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;
    localparam logic [8:0] CONV_LAST = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] PH_LAST   = 9'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST  = 6'(FRAME_LEN - 1);
    localparam int         CH0_MSB   = FRAME_LEN - 3;
    localparam int         CH1_MSB   = FRAME_LEN - 19;
    state_t                 state_q, state_d;
    logic [8:0]             cnt_q, cnt_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [FRAME_LEN-1:0]   sr_q, sr_d;
    logic                   sck_q, sck_d, ad_conv_q, ad_conv_d, busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0]      ch0_q, ch0_d, ch1_q, ch1_d;
    logic                   conv_end, ph_end, cap, last_cap;
    assign conv_end = state_q == CONV && cnt_q == CONV_LAST;
    assign ph_end   = state_q == SHIFT && cnt_q == PH_LAST;
    // capture on the edge that ends a high phase, i.e. the one that drops SCK
    assign cap      = ph_end && sck_q;
    assign last_cap = cap && bit_cnt_q == BIT_LAST;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            sck_q     <= 1'b0;
            ad_conv_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ch0_q     <= '0;
            ch1_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            sck_q     <= sck_d;
            ad_conv_q <= ad_conv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ch0_q     <= ch0_d;
            ch1_q     <= ch1_d;
        end
    end
    always_comb begin
        state_d = (state_q == IDLE && GO_ADC) ? CONV  :
                  conv_end                    ? SHIFT :
                  last_cap                    ? DONE  :
                  (state_q == DONE)           ? IDLE  : state_q;
    end
    always_comb begin
        cnt_d     = (state_q == CONV || state_q == SHIFT) ? ((conv_end || ph_end) ? 9'd0 : cnt_q + 9'd1) : 9'd0;
        sck_d     = state_q == SHIFT && (sck_q ^ ph_end);
        bit_cnt_d = last_cap ? 6'd0 : cap ? bit_cnt_q + 6'd1 : bit_cnt_q;
        sr_d      = cap ? {sr_q[FRAME_LEN-2:0], SPI_MISO} : sr_q;
        ch0_d     = last_cap ? sr_d[CH0_MSB -: DATA_W] : ch0_q;
        ch1_d     = last_cap ? sr_d[CH1_MSB -: DATA_W] : ch1_q;
        ad_conv_d = state_d == CONV;
        busy_d    = state_d != IDLE;
        done_d    = state_d == DONE;
    end
    assign AD_CONV     = ad_conv_q;
    assign SPI_CLK_ADC = sck_q;
    assign BUSY        = busy_q;
    assign DONE_ADC    = done_q;
    assign ADC_CH0     = ch0_q;
    assign ADC_CH1     = ch1_q;
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed bench for adc_capture at CLK_DIV=2 (instance a) and CLK_DIV=1 (instance b)
module tb_adc_capture;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a, go_a, miso_a, conv_a, sck_a, busy_a, done_a;
    logic rst_b, go_b, miso_b, conv_b, sck_b, busy_b, done_b;
    logic [13:0] ch0_a, ch1_a, ch0_b, ch1_b;
    logic [33:0] fr_a, fr_b;
    logic [13:0] hold0, hold1;
    int ia = 0, ib = 0;
    int n_vec = 0, n_bad = 0;
    adc_capture #(.CLK_DIV(2)) dut_a (
        .clk(clk), .reset(rst_a), .GO_ADC(go_a), .SPI_MISO(miso_a), .AD_CONV(conv_a),
        .SPI_CLK_ADC(sck_a), .BUSY(busy_a), .DONE_ADC(done_a), .ADC_CH0(ch0_a), .ADC_CH1(ch1_a));
    adc_capture #(.CLK_DIV(1)) dut_b (
        .clk(clk), .reset(rst_b), .GO_ADC(go_b), .SPI_MISO(miso_b), .AD_CONV(conv_b),
        .SPI_CLK_ADC(sck_b), .BUSY(busy_b), .DONE_ADC(done_b), .ADC_CH0(ch0_b), .ADC_CH1(ch1_b));
    always @(posedge conv_a or negedge sck_a) ia <= conv_a ? 0 : ia + 1;
    always @(posedge conv_b or negedge sck_b) ib <= conv_b ? 0 : ib + 1;
    assign miso_a = (ia < 34) ? fr_a[33-ia] : 1'b1;
    assign miso_b = (ib < 34) ? fr_b[33-ib] : 1'b1;
    function automatic logic [33:0] mk(input logic [13:0] c0, input logic [13:0] c1);
        return {2'b11, c0, 2'b11, c1, 2'b11};
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic frame_a(input logic [13:0] c0, input logic [13:0] c1, input bit pulses);
        int convs, rises, done_at, busy_n, late;
        logic prev;
        convs = 0; rises = 0; done_at = 0; busy_n = 0; late = 0; prev = 1'b0;
        fr_a = mk(c0, c1);
        @(negedge clk) go_a = 1'b1;
        for (int k = 1; k <= 300 && done_at == 0; k++) begin
            @(negedge clk);
            go_a = pulses && (k == 10 || k == 60 || k == 140);
            convs += int'(conv_a);
            if (sck_a && !prev) rises++;
            prev = sck_a;
            busy_n += int'(busy_a);
            if (k == 100) begin
                chk("hold_ch0", 32'(ch0_a), 32'(hold0));
                chk("hold_ch1", 32'(ch1_a), 32'(hold1));
            end
            if (done_a) done_at = k;
        end
        go_a = 1'b0;
        chk("conv_cycles", convs, 4);
        chk("sck_rises", rises, 34);
        chk("done_cycle", done_at, 141);
        chk("busy_cycles", busy_n, 141);
        chk("ch0", 32'(ch0_a), 32'(c0));
        chk("ch1", 32'(ch1_a), 32'(c1));
        hold0 = c0;
        hold1 = c1;
        @(negedge clk);
        chk("done_one_cycle", 32'(done_a), 0);
        chk("busy_after_done", 32'(busy_a), 0);
        if (pulses) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                late += int'(conv_a) + int'(busy_a);
            end
            chk("no_queued_frame", late, 0);
        end
    endtask
    initial begin
        logic [13:0] b0 [3];
        logic [13:0] b1 [3];
        int dones, idle_done;
        b0 = '{14'h2ABC, 14'h2000, 14'h3FFF};
        b1 = '{14'h1555, 14'h1FFF, 14'h0001};
        fr_a = '1; fr_b = '1;
        hold0 = '0; hold1 = '0;
        rst_a = 1'b0; rst_b = 1'b0; go_a = 1'b1; go_b = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("reset_a", {conv_a, sck_a, busy_a, done_a, ch0_a, ch1_a}, 32'd0);
            chk("reset_b", {conv_b, sck_b, busy_b, done_b, ch0_b, ch1_b}, 32'd0);
        end
        go_a = 1'b0; go_b = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {conv_a, busy_a, conv_b, busy_b}, 32'd0);
        frame_a(14'h2ABC, 14'h1555, 1'b0);
        frame_a(14'h2000, 14'h1FFF, 1'b0);
        frame_a(14'h3FFF, 14'h0000, 1'b0);
        frame_a(14'h0F0F, 14'h30F0, 1'b1);
        fr_a = mk(14'h1234, 14'h0ABC);
        @(negedge clk) go_a = 1'b1;
        @(negedge clk) go_a = 1'b0;
        repeat (89) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        chk("midreset_sck", 32'(sck_a), 0);
        chk("midreset_busy", 32'(busy_a), 0);
        chk("midreset_done", 32'(done_a), 0);
        chk("midreset_ch", {ch0_a, ch1_a}, 32'd0);
        idle_done = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            idle_done += int'(done_a) + int'(busy_a);
        end
        chk("no_partial_done", idle_done, 0);
        hold0 = '0; hold1 = '0;
        frame_a(14'h1234, 14'h0ABC, 1'b0);
        dones = 0;
        fr_b = mk(b0[0], b1[0]);
        @(negedge clk) go_b = 1'b1;
        for (int k = 1; k <= 260 && dones < 3; k++) begin
            @(negedge clk);
            if (done_b) begin
                chk("b_done_cycle", k, 71 + 72 * dones);
                chk("b_ch0", 32'(ch0_b), 32'(b0[dones]));
                chk("b_ch1", 32'(ch1_b), 32'(b1[dones]));
                dones++;
                if (dones < 3) fr_b = mk(b0[dones], b1[dones]);
            end
        end
        go_b = 1'b0;
        chk("b_frames", dones, 3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
